dcache_req_skid_pipe: RTL and testbench

Two-entry, branch-killable skid pipeline sitting directly downstream of the LSU branch-killable request queue, between that queue's dequeue port and the DCache s0 request port. It fully registers the request path and its ready, so the queue's combinational kill/flush logic does not reach the DCache. While an entry is held, its `br_mask` is updated and the entry can be killed, exactly as entries inside the queue are.

---
 rtl/dcache_req_skid_pipe_pkg.sv | 45 ++++
 rtl/dcache_req_skid_pipe_slot.sv | 47 ++++
 rtl/dcache_req_skid_pipe.sv | 101 ++++++++++
 tb/tb_dcache_req_skid_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dcache_req_skid_pipe_pkg.sv
// Shared LSU request types and branch-mask helpers for the DCache request path.
// No state: types, widths and pure functions only.
// Not applicable: no handshakes live here.
package dcache_req_skid_pipe_pkg;

  localparam int maxBrCount = 8;

  typedef logic [maxBrCount-1:0] br_mask_t;

  typedef struct packed {
    br_mask_t resolve_mask;
    br_mask_t mispredict_mask;
  } BrUpdateB1ST;

  typedef struct packed {
    BrUpdateB1ST b1;
  } BrUpdateInfoST;

  typedef struct packed {
    br_mask_t   br_mask;
    logic       uses_ldq;
    logic [7:0] rob_idx;
  } MicroOpST;

  typedef struct packed {
    MicroOpST    uop;
    logic [15:0] addr;
  } BoomDCacheReqInternalST;

  // Clear the branches that resolved this cycle from a mask.
  function automatic br_mask_t getNewBrMask(input BrUpdateInfoST brupdate, input br_mask_t mask);
    return mask & ~brupdate.b1.resolve_mask;
  endfunction

  // True when the entry depends on any mispredicted branch.
  function automatic logic maskMatch(input br_mask_t mask, input br_mask_t kill);
    return (mask & kill) != '0;
  endfunction

  // A flush only removes memory ops that own a load-queue entry.
  function automatic logic flush_fn(input logic flush, input MicroOpST uop);
    return flush && uop.uses_ldq;
  endfunction

endpackage

// File: rtl/dcache_req_skid_pipe_slot.sv
// One branch-killable storage slot: holds an entry and ages its branch mask.
// Latency: load visible the cycle after the edge; dies is combinational.
// Backpressure: none internally; the parent decides load/clear every cycle.
module killable_slot
  import dcache_req_skid_pipe_pkg::*;
#(
  parameter type T = BoomDCacheReqInternalST
) (
  input  logic          clock,
  input  logic          reset,
  input  BrUpdateInfoST brupdate,
  input  logic          flush,
  input  logic          load,
  input  T              load_dat,
  input  logic          clear,
  output logic          vld,
  output T              dat,
  output logic          dies
);

  T q;

  // Present the held entry with this cycle's resolutions already applied.
  always_comb begin
    dat = q;
    dat.uop.br_mask = getNewBrMask(brupdate, q.uop.br_mask);
  end

  // Kill uses the mask as held, before this cycle's resolve is applied.
  assign dies = vld && (maskMatch(q.uop.br_mask, brupdate.b1.mispredict_mask) ||
                        flush_fn(flush, q.uop));

  // Clear wins over load; an idle valid slot keeps ageing its mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= load_dat;
    end else if (vld) begin
      q   <= dat;
    end
  end

endmodule

// File: rtl/dcache_req_skid_pipe.sv
// Two-entry branch-killable skid pipe between the LSU request queue and DCache s0.
// Latency: 1 cycle from in_fire to o_out_valid, no flow-through; 1 entry/cycle sustained.
// Backpressure: o_in_ready is !skid.valid, so upstream stalls the cycle after skid fills.
module dcache_req_skid_pipe
  import dcache_req_skid_pipe_pkg::*;
#(
  parameter type T = BoomDCacheReqInternalST
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_in_valid,
  input  T              i_in,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output T              o_out,
  input  logic          i_out_ready,
  input  BrUpdateInfoST i_brupdate,
  input  logic          i_flush,
  output logic [1:0]    o_count,
  output logic          o_empty
);

  logic main_vld, main_dies, main_load, main_clear;
  logic skid_vld, skid_dies, skid_load, skid_clear;
  T     main_dat, skid_dat, main_load_dat, in_upd;
  logic in_fire, in_dies, in_surv, out_fire;
  logic main_surv, skid_surv, main_keep;

  // Incoming entry gets the same mask ageing as held ones before it is written.
  always_comb begin
    in_upd = i_in;
    in_upd.uop.br_mask = getNewBrMask(i_brupdate, i_in.uop.br_mask);
  end

  assign in_dies   = maskMatch(i_in.uop.br_mask, i_brupdate.b1.mispredict_mask) ||
                     flush_fn(i_flush, i_in.uop);
  assign o_in_ready  = !skid_vld && !reset;
  assign in_fire     = i_in_valid && o_in_ready;
  assign in_surv     = in_fire && !in_dies;

  assign main_surv   = main_vld && !main_dies;
  assign skid_surv   = skid_vld && !skid_dies;
  assign o_out_valid = main_surv && !reset;
  assign o_out       = main_dat;
  assign out_fire    = o_out_valid && i_out_ready;
  assign main_keep   = main_surv && !out_fire;

  // Age-ordered refill: main, then skid, then the incoming entry.
  always_comb begin
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_load_dat = in_upd;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (main_keep) begin
      if (!skid_surv) begin
        skid_load  = in_surv;
        skid_clear = !in_surv;
      end
    end else if (skid_surv) begin
      main_load     = 1'b1;
      main_load_dat = skid_dat;
      skid_load     = in_surv;
      skid_clear    = !in_surv;
    end else begin
      main_load  = in_surv;
      main_clear = !in_surv;
      skid_clear = 1'b1;
    end
  end

  killable_slot #(.T(T)) u_main (
    .clock    (clock),
    .reset    (reset),
    .brupdate (i_brupdate),
    .flush    (i_flush),
    .load     (main_load),
    .load_dat (main_load_dat),
    .clear    (main_clear),
    .vld      (main_vld),
    .dat      (main_dat),
    .dies     (main_dies)
  );

  killable_slot #(.T(T)) u_skid (
    .clock    (clock),
    .reset    (reset),
    .brupdate (i_brupdate),
    .flush    (i_flush),
    .load     (skid_load),
    .load_dat (in_upd),
    .clear    (skid_clear),
    .vld      (skid_vld),
    .dat      (skid_dat),
    .dies     (skid_dies)
  );

  assign o_count = {1'b0, main_vld} + {1'b0, skid_vld};
  assign o_empty = (o_count == 2'd0);

endmodule

// File: tb/tb_dcache_req_skid_pipe.sv
// Bench for dcache_req_skid_pipe: directed scenarios then random traffic.
// Reference is an age-ordered queue filtered each cycle by kill/flush/fire.
// Outputs sampled on the falling edge; inputs driven just after the rising edge.
module tb_dcache_req_skid_pipe;
  import dcache_req_skid_pipe_pkg::*;

  typedef BoomDCacheReqInternalST req_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_in_valid;
  req_t          i_in;
  logic          o_in_ready;
  logic          o_out_valid;
  req_t          o_out;
  logic          i_out_ready;
  BrUpdateInfoST i_brupdate;
  logic          i_flush;
  logic [1:0]    o_count;
  logic          o_empty;

  int n_tests = 0;
  int n_fail  = 0;
  req_t mq[$];

  always #5 clock = ~clock;

  dcache_req_skid_pipe dut (
    .clock       (clock),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .i_in        (i_in),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out       (o_out),
    .i_out_ready (i_out_ready),
    .i_brupdate  (i_brupdate),
    .i_flush     (i_flush),
    .o_count     (o_count),
    .o_empty     (o_empty)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic req_t mk(input logic [7:0] mask, input logic ldq, input logic [7:0] tag);
    req_t r;
    r.uop.br_mask  = mask;
    r.uop.uses_ldq = ldq;
    r.uop.rob_idx  = tag;
    r.addr         = {tag, ~tag};
    return r;
  endfunction

  function automatic bit m_dies(input req_t r, input br_mask_t misp, input bit fl);
    return ((r.uop.br_mask & misp) != 0) || (fl && r.uop.uses_ldq);
  endfunction

  function automatic req_t m_age(input req_t r, input br_mask_t res);
    req_t a = r;
    a.uop.br_mask = r.uop.br_mask & ~res;
    return a;
  endfunction

  // Drive one cycle, check outputs against the queue model, then advance the model.
  task automatic step(input bit iv, input req_t p, input bit ordy, input br_mask_t misp,
                      input br_mask_t res, input bit fl, input bit rst);
    bit   exp_vld, exp_rdy, fired;
    req_t nq[$];
    reset                          = rst;
    i_in_valid                     = iv;
    i_in                           = p;
    i_out_ready                    = ordy;
    i_brupdate.b1.mispredict_mask  = misp;
    i_brupdate.b1.resolve_mask     = res;
    i_flush                        = fl;
    @(negedge clock);
    exp_vld = !rst && mq.size() > 0 && !m_dies(mq[0], misp, fl);
    exp_rdy = !rst && mq.size() < 2;
    check_eq("out_valid", o_out_valid, exp_vld);
    check_eq("in_ready",  o_in_ready,  exp_rdy);
    check_eq("count",     o_count,     mq.size());
    check_eq("empty",     o_empty,     mq.size() == 0);
    if (exp_vld) check_eq("out_payload", o_out, m_age(mq[0], res));
    if (rst) begin
      mq.delete();
    end else begin
      fired = exp_vld && ordy;
      foreach (mq[i]) begin
        if (!(i == 0 && fired) && !m_dies(mq[i], misp, fl)) nq.push_back(m_age(mq[i], res));
      end
      if (iv && exp_rdy && !m_dies(p, misp, fl)) nq.push_back(m_age(p, res));
      mq = nq;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, ordy, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    req_t r;
    br_mask_t misp, res;
    reset       = 1'b1;
    i_in_valid  = 1'b0;
    i_in        = '0;
    i_out_ready = 1'b0;
    i_brupdate  = '0;
    i_flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    // Reset state
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

    // Streaming A, B, C
    step(1'b1, mk(8'h00, 1'b0, 8'hA0), 1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, mk(8'h00, 1'b0, 8'hB0), 1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, mk(8'h00, 1'b0, 8'hC0), 1'b1, '0, '0, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // Backpressure then release
    step(1'b1, mk(8'h00, 1'b0, 8'hA1), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, mk(8'h00, 1'b0, 8'hB1), 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // Mispredict kills main only
    step(1'b1, mk(8'h04, 1'b0, 8'hA2), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, mk(8'h00, 1'b0, 8'hB2), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8'h04, '0, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // Resolve then a mispredict on the resolved bit
    step(1'b1, mk(8'h06, 1'b0, 8'hA3), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 8'h02, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 8'h02, '0, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // Flush removes only the load-queue entry
    step(1'b1, mk(8'h00, 1'b1, 8'hA4), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, mk(8'h00, 1'b0, 8'hB4), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Reset with two entries held
    step(1'b1, mk(8'h00, 1'b0, 8'hA5), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, mk(8'h00, 1'b0, 8'hB5), 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, '0, 1'b0, 1'b1);
    repeat (3) idle(1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r.uop.br_mask  = br_mask_t'($urandom);
      r.uop.uses_ldq = 1'($urandom);
      r.uop.rob_idx  = 8'($urandom);
      r.addr         = 16'($urandom);
      misp = ($urandom_range(0, 7) == 0) ? br_mask_t'(1 << $urandom_range(0, maxBrCount - 1)) : '0;
      res  = ($urandom_range(0, 3) == 0) ? br_mask_t'($urandom) : '0;
      step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0), misp, res,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
